alu_result_serializer: RTL and testbench

Downstream stage of the 4-bit ALU top (`tt_um_Richard28277`). It accepts 8-bit ALU results over a valid/ready handshake and buffers them in a small FIFO. Each result is shifted out MSB-first on a single pin, with a bit strobe, a frame signal and an even-parity bit, so results can be read off a few bidirectional pins by an external logic analyser or MCU.

---
 rtl/alu_ser_pkg.sv | 22 ++
 rtl/alu_ser_if.sv | 29 ++
 rtl/alu_ser_fifo.sv | 70 +++++++
 rtl/alu_result_serializer.sv | 183 ++++++++++++++++++
 tb/tb_alu_result_serializer.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ser_pkg.sv
// alu_ser_pkg
// Shared definitions for the ALU result serializer slice: the default
// geometry constants and the serializer FSM state encoding. The encoding
// is fixed so that a logic analyser probing the state register sees
// stable codes across builds.
package alu_ser_pkg;

  // Default result width, FIFO depth and clock cycles per serial bit
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 2;
  localparam int DEFAULT_DIV    = 4;

  // Serializer FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } serState_t;

endpackage

// File: rtl/alu_ser_if.sv
// alu_ser_if
// Valid/ready handshake bundle carrying ALU results into the serializer.
//   in_valid : producer has a result on in_data
//   in_ready : serializer FIFO can take a result this cycle
//   in_data  : DATA_W-bit ALU result
// Modports:
//   master : the producer (ALU side or testbench)
//   slave  : the serializer
interface alu_ser_if #(
  parameter int DATA_W = alu_ser_pkg::DEFAULT_DATA_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/alu_ser_fifo.sv
// alu_ser_fifo
// DEPTH-entry synchronous FIFO buffering ALU results ahead of the
// serializer. Pointers carry one extra wrap bit so full and empty can be
// told apart without a separate counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   i_ena       : global enable; low holds both pointers
//   i_push      : write i_pushData this cycle (ignored when full)
//   i_pushData  : data to write
//   i_pop       : drop the head entry this cycle (ignored when empty)
//   o_popData   : current head entry
//   o_full      : all DEPTH entries occupied
//   o_empty     : no entries held
module alu_ser_fifo import alu_ser_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ena,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_pushData,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_popData,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wrPtr;
  logic [PW-1:0]     r_rdPtr;
  logic              w_push;
  logic              w_pop;

  assign w_push = i_ena && i_push && !o_full;
  assign w_pop  = i_ena && i_pop && !o_empty;

  // Same index with differing wrap bits means the writer has lapped the reader
  assign o_empty   = (r_wrPtr == r_rdPtr);
  assign o_full    = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) &&
                     (r_wrPtr[AW] != r_rdPtr[AW]);
  assign o_popData = r_mem[r_rdPtr[AW-1:0]];

  // Pointer update; reset returns both pointers to zero so the FIFO
  // comes back empty even if reset lands in the middle of a burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
    end
  end

  // Storage array; contents need no reset because empty pointers hide them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
    end
  end

endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer
// Takes ALU results over a valid/ready handshake, buffers them in a small
// FIFO and shifts each one out MSB-first on a single pin followed by an
// even-parity bit. Each bit lasts DIV clock cycles; ser_clk is low for the
// first half of a bit and high for the second half, so an external reader
// can sample ser_data on the ser_clk rising edge. ser_frame brackets the
// data and parity bits, and one idle bit period (GAP) separates frames.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : global enable; low freezes every register
//   bus        : alu_ser_if slave (in_valid, in_ready, in_data)
//   ser_data   : serial bit, MSB first, then parity
//   ser_clk    : bit strobe, high in the second half of each bit
//   ser_frame  : high across the data and parity bits of a frame
//   busy       : FIFO holds results or a frame is in flight
module alu_result_serializer import alu_ser_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DIV    = DEFAULT_DIV
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ena,
  alu_ser_if.slave bus,
  output logic     ser_data,
  output logic     ser_clk,
  output logic     ser_frame,
  output logic     busy
);

  localparam int DIV_W = $clog2(DIV);
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_PAR   = BIT_W'(DATA_W);

  serState_t         r_state;
  logic [DIV_W-1:0]  r_divCnt;
  logic [BIT_W-1:0]  r_bitCnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic              r_serData;
  logic              r_serClk;
  logic              r_serFrame;
  logic              r_busy;
  logic              r_started;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;
  logic [DIV_W-1:0]  w_divNext;

  // in_ready looks only at the registered full flag, so a pop in the same
  // cycle never re-opens a full FIFO; r_started keeps it low until the
  // first clock edge after reset
  assign bus.in_ready = ena && !w_full && r_started;
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = ena && (r_state == ST_LOAD);
  assign w_divNext    = r_divCnt + DIV_W'(1);

  assign ser_data  = r_serData;
  assign ser_clk   = r_serClk;
  assign ser_frame = r_serFrame;
  assign busy      = r_busy;

  alu_ser_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ena      (ena),
    .i_push     (w_push),
    .i_pushData (bus.in_data),
    .i_pop      (w_pop),
    .o_popData  (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Marks that at least one clock edge has been seen since reset released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
    end
  end

  // Serializer FSM with the divide counter, bit counter, shift register,
  // parity register and all serial outputs registered together. Every
  // output is set on the edge that enters the cycle it describes, so
  // ser_clk is computed from the divide count about to be loaded.
  // The bit counter runs 0..DATA_W across the data bits and the parity
  // bit, wrapping to 0 as the frame closes. When GAP finishes with more
  // results queued the FSM goes straight to LOAD, so back-to-back frames
  // are separated only by GAP plus the one LOAD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_divCnt   <= '0;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_serData  <= 1'b0;
      r_serClk   <= 1'b0;
      r_serFrame <= 1'b0;
      r_busy     <= 1'b0;
    end else if (ena) begin
      unique case (r_state)
        ST_IDLE: begin
          r_busy <= !w_empty || w_push;
          if (!w_empty) begin
            r_state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          r_shift    <= {w_head[DATA_W-2:0], 1'b0};
          r_serData  <= w_head[DATA_W-1];
          r_parity   <= ^w_head;
          r_serFrame <= 1'b1;
          r_serClk   <= 1'b0;
          r_divCnt   <= '0;
          r_bitCnt   <= '0;
          r_busy     <= 1'b1;
          r_state    <= ST_SHIFT;
        end

        ST_SHIFT, ST_PARITY: begin
          r_busy <= 1'b1;
          if (r_divCnt == DIV_LAST) begin
            r_divCnt <= '0;
            r_serClk <= 1'b0;
            if (r_bitCnt == BIT_PAR) begin
              r_bitCnt   <= '0;
              r_serFrame <= 1'b0;
              r_serData  <= 1'b0;
              r_state    <= ST_GAP;
            end else begin
              r_bitCnt <= r_bitCnt + BIT_W'(1);
              if (r_bitCnt == BIT_LAST) begin
                r_serData <= r_parity;
                r_state   <= ST_PARITY;
              end else begin
                r_serData <= r_shift[DATA_W-1];
                r_shift   <= r_shift << 1;
              end
            end
          end else begin
            r_divCnt <= w_divNext;
            r_serClk <= (w_divNext >= DIV_HALF);
          end
        end

        ST_GAP: begin
          if (r_divCnt == DIV_LAST) begin
            r_divCnt <= '0;
            if (!w_empty) begin
              r_state <= ST_LOAD;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= w_push;
            end
          end else begin
            r_divCnt <= w_divNext;
            r_busy   <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer
// Directed bench for alu_result_serializer with DATA_W=8, DEPTH=2, DIV=4.
// Single-frame vectors come from a table of {result, expected 9-bit
// serial word}; burst, reset, enable-freeze and streaming cases are
// written out by hand.
module tb_alu_result_serializer;

  localparam int DATA_W     = 8;
  localparam int DEPTH      = 2;
  localparam int DIV        = 4;
  localparam int FRAME_HIGH = (DATA_W + 1) * DIV;

  typedef struct {
    logic [7:0] data;
    logic [8:0] expSerial;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic serData;
  logic serClk;
  logic serFrame;
  logic busy;

  int total = 0;
  int bad   = 0;

  vec_t vecs [8];

  alu_ser_if #(.DATA_W(DATA_W)) bus ();

  alu_result_serializer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DIV    (DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .bus       (bus),
    .ser_data  (serData),
    .ser_clk   (serClk),
    .ser_frame (serFrame),
    .busy      (busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside a bounded wait
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports a failure line on mismatch
  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  // Offer one result and hold it until it is taken, then drop in_valid
  task automatic applyStimulus(input logic [7:0] d);
    int guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL pushTimeout: got in_ready=0 want in_ready=1 within 200 cycles");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Wait for a frame, count its high cycles and collect ser_data at each
  // ser_clk rising edge; returns at the first negedge with ser_frame low
  task automatic captureFrame(input string tag, output logic [8:0] bits,
                              output int high, output int nb);
    int   guard   = 0;
    logic prevClk = 1'b0;
    bits = '0;
    high = 0;
    nb   = 0;
    while (!serFrame && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!serFrame) begin
      total++;
      bad++;
      $display("[TB] FAIL %s frameStart: got no frame want frame within 400 cycles", tag);
      return;
    end
    while (serFrame && high < 200) begin
      high++;
      if (serClk && !prevClk) begin
        bits = {bits[7:0], serData};
        nb++;
      end
      prevClk = serClk;
      @(negedge clk);
    end
  endtask

  // Cycles with ser_frame low before the next frame starts
  task automatic countLow(output int n);
    n = 0;
    while (!serFrame && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Cycles busy stays high from now on
  task automatic countBusy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Full frame check against an expected serial word and high time
  task automatic checkFrame(input string tag, input logic [8:0] expSerial, input int expHigh);
    logic [8:0] bits;
    int         high;
    int         nb;
    captureFrame(tag, bits, high, nb);
    checkOutput({tag, ".serial"}, int'(bits), int'(expSerial));
    checkOutput({tag, ".bitCount"}, nb, 9);
    checkOutput({tag, ".frameHigh"}, high, expHigh);
  endtask

  // Burst of three pushes on consecutive cycles into a depth-2 FIFO
  task automatic burstPushes();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h0F;
    checkOutput("burst.readyFirst", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_data = 8'hF0;
    checkOutput("burst.readySecond", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_data = 8'h3C;
    checkOutput("burst.readyFull", int'(bus.in_ready), 0);
    @(negedge clk);
    checkOutput("burst.readyAfterPop", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Watches the three burst frames and the gaps between them
  task automatic burstFrames();
    int n;
    checkFrame("burst0F", 9'b000011110, FRAME_HIGH);
    countLow(n);
    checkOutput("burst.gap1", n, 5);
    checkFrame("burstF0", 9'b111100000, FRAME_HIGH);
    countLow(n);
    checkOutput("burst.gap2", n, 5);
    checkFrame("burst3C", 9'b001111000, FRAME_HIGH);
    countBusy(n);
    checkOutput("burst.busyTail", n, 4);
  endtask

  // Freeze the DUT for 7 cycles in bit 3 of a 0x96 frame (bit 3 = 1,
  // first half of the bit so ser_clk = 0)
  task automatic freezeMidShift();
    int guard = 0;
    while (!serFrame && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    repeat (13) @(negedge clk);
    checkOutput("freeze.dataBefore", int'(serData), 1);
    checkOutput("freeze.clkBefore", int'(serClk), 0);
    ena = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput($sformatf("freeze%0d.data", i), int'(serData), 1);
      checkOutput($sformatf("freeze%0d.clk", i), int'(serClk), 0);
      checkOutput($sformatf("freeze%0d.frame", i), int'(serFrame), 1);
      checkOutput($sformatf("freeze%0d.ready", i), int'(bus.in_ready), 0);
    end
    ena = 1'b1;
  endtask

  // Keep offering 0x00 until ten results have been taken
  task automatic streamPushes(output int pushes);
    int guard = 0;
    pushes = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    while (guard < 2000) begin
      if (bus.in_ready) begin
        pushes++;
      end
      if (pushes == 10) begin
        break;
      end
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Ten zero frames back to back, then nothing more
  task automatic streamFrames();
    int n;
    int extra = 0;
    for (int i = 0; i < 10; i++) begin
      checkFrame($sformatf("stream%0d", i), 9'b000000000, FRAME_HIGH);
      if (i < 9) begin
        countLow(n);
        checkOutput($sformatf("stream%0d.gap", i), n, 5);
      end
    end
    countBusy(n);
    checkOutput("stream.busyTail", n, 4);
    repeat (60) begin
      @(negedge clk);
      if (serFrame) begin
        extra++;
      end
    end
    checkOutput("stream.extraFrameCycles", extra, 0);
  endtask

  initial begin
    int n;
    int pushes;

    vecs[0] = '{data: 8'hA5, expSerial: 9'b101001010};
    vecs[1] = '{data: 8'h01, expSerial: 9'b000000011};
    vecs[2] = '{data: 8'hFF, expSerial: 9'b111111110};
    vecs[3] = '{data: 8'h80, expSerial: 9'b100000001};
    vecs[4] = '{data: 8'h7E, expSerial: 9'b011111100};
    vecs[5] = '{data: 8'hB3, expSerial: 9'b101100111};
    vecs[6] = '{data: 8'h00, expSerial: 9'b000000000};
    vecs[7] = '{data: 8'h6D, expSerial: 9'b011011011};

    rst_n        = 1'b0;
    ena          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("reset.inReady", int'(bus.in_ready), 0);
    checkOutput("reset.serData", int'(serData), 0);
    checkOutput("reset.serClk", int'(serClk), 0);
    checkOutput("reset.serFrame", int'(serFrame), 0);
    checkOutput("reset.busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset.inReadyRise", int'(bus.in_ready), 1);

    // Single frames from the table
    for (int v = 0; v < 8; v++) begin
      string tag;
      tag = $sformatf("vec%0d_%02h", v, vecs[v].data);
      applyStimulus(vecs[v].data);
      checkFrame(tag, vecs[v].expSerial, FRAME_HIGH);
      checkOutput({tag, ".dataAfter"}, int'(serData), 0);
      countBusy(n);
      checkOutput({tag, ".busyTail"}, n, 4);
      checkOutput({tag, ".busyLow"}, int'(busy), 0);
    end

    // Three pushes on consecutive cycles
    fork
      burstPushes();
      burstFrames();
    join

    // Reset pulse during bit 3 of a frame
    applyStimulus(8'h5A);
    n = 0;
    while (!serFrame && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (13) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.serFrame", int'(serFrame), 0);
    checkOutput("midReset.serData", int'(serData), 0);
    checkOutput("midReset.serClk", int'(serClk), 0);
    checkOutput("midReset.busy", int'(busy), 0);
    checkOutput("midReset.inReady", int'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("afterReset.busy", int'(busy), 0);
    checkOutput("afterReset.serFrame", int'(serFrame), 0);
    applyStimulus(8'hC3);
    checkFrame("afterResetC3", 9'b110000110, FRAME_HIGH);
    countBusy(n);
    checkOutput("afterResetC3.busyTail", n, 4);

    // Enable dropped for 7 cycles mid-SHIFT
    applyStimulus(8'h96);
    fork
      checkFrame("freeze96", 9'b100101100, FRAME_HIGH + 7);
      freezeMidShift();
    join
    countBusy(n);
    checkOutput("freeze96.busyTail", n, 4);

    // Continuous in_valid with 0x00 for ten frames
    fork
      streamPushes(pushes);
      streamFrames();
    join
    checkOutput("stream.pushesTaken", pushes, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
